// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// Optional memory-handshake watchdog enabled by defining MC_TIMEOUT_EN.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        alu_src_imm,
    output logic        mem_to_reg,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        mem_timeout,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_e;

    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BAD} iclass_e;

    state_e      state_q, state_d;
    iclass_e     class_q, class_d, dec_class;
    logic [3:0]  alu_op_q, alu_op_d, dec_alu_op;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    logic        started_q;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        dec_class  = C_BAD;
        dec_alu_op = 4'b0000;
        unique case (instr[6:0])
            7'b0110011: begin
                dec_class  = C_R;
                dec_alu_op = {instr[30], instr[14:12]};
            end
            7'b0010011: begin
                dec_class  = C_I;
                dec_alu_op = {(instr[14:12] == 3'b101) ? instr[30] : 1'b0, instr[14:12]};
            end
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            default:    dec_class = C_BAD;
        endcase
    end

`ifdef MC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    assign mem_timeout = mem_timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign mem_timeout = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        alu_op_d    = alu_op_q;
        illegal_d   = illegal_q;
        retired_d   = retired_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_imm = 1'b0;
        mem_to_reg  = 1'b0;
        alu_op      = 4'b0000;

        case (state_q)
            S_FETCH: begin
                // Held off for one edge after reset release.
                mem_req = started_q;
                if (started_q && mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_op   = dec_alu_op;
                alu_op_d = dec_alu_op;
                class_d  = dec_class;
                if (dec_class == C_BAD) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_op      = alu_op_q;
                alu_src_imm = (class_q != C_R);
                state_d     = (class_q == C_LOAD || class_q == C_STORE) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                alu_op      = alu_op_q;
                alu_src_imm = 1'b1;
                mem_req     = 1'b1;
                mem_we      = (class_q == C_STORE);
                if (mem_ready) begin
                    if (class_q == C_STORE) begin
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                alu_op      = alu_op_q;
                alu_src_imm = (class_q != C_R);
                reg_write   = 1'b1;
                mem_to_reg  = (class_q == C_LOAD);
                retired_d   = retired_q + 32'd1;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

`ifdef MC_TIMEOUT_EN
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (mem_req && !mem_ready) begin
            if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                mem_timeout_d = 1'b1;
                state_d       = S_TRAP;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_R;
            alu_op_q  <= 4'b0000;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            started_q <= 1'b1;
        end
    end

`ifdef MC_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
`endif

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
